// File: rtl/acc_thread_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_thread_scheduler_pkg
//  Description : Shared definitions for the lookup-accelerator thread
//                scheduler: slot state encodings and the thread-id / action
//                width defaults that are also used by the accelerator.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_thread_scheduler_pkg;

    // Widths shared with the accelerator interface
    localparam int c_TID_WIDTH_DEFAULT   = 3;
    localparam int c_NUM_ACTIONS_DEFAULT = 4;

    // Per-thread request slot state
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_INFLIGHT = 2'd2,
        ST_DONE     = 2'd3
    } slot_state_e;

endpackage : acc_thread_scheduler_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches i_req starting
//                at i_ptr, wrapping NUM_THREADS-1 -> 0, and returns the first
//                requester as a one-hot grant plus its encoded index.
//  Ports       : i_req         - request vector
//                i_ptr         - index where the search starts
//                o_grant       - one-hot grant (all zero when no request)
//                o_grant_idx   - encoded index of the granted requester
//                o_grant_valid - a grant was made this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_THREADS = 8,
    parameter int IDX_WIDTH   = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0] i_req,
    input  logic [IDX_WIDTH-1:0]   i_ptr,
    output logic [NUM_THREADS-1:0] o_grant,
    output logic [IDX_WIDTH-1:0]   o_grant_idx,
    output logic                   o_grant_valid
);

    always_comb begin
        int cand;
        cand          = 0;
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cand = int'(i_ptr) + i;
            if (cand >= NUM_THREADS) begin
                cand = cand - NUM_THREADS;
            end
            // First hit along the rotated order wins; later hits are ignored
            if (!o_grant_valid && i_req[cand]) begin
                o_grant_valid = 1'b1;
                o_grant[cand] = 1'b1;
                o_grant_idx   = IDX_WIDTH'(cand);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/acc_thread_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : acc_thread_scheduler
//  Description : Upstream feeder for the source-IP lookup accelerator.
//                Holds one request slot per hardware thread, issues pending
//                requests round-robin (at most one per cycle, none while the
//                flow table is being programmed), routes results back by
//                thread id and forces a slot DONE with an error if its
//                result does not return within TIMEOUT cycles.
//  Ports       : clk, reset_n                  - clock, async active-low reset
//                req_valid/req_ip/req_ack      - per-thread request capture
//                rsp_valid/action/match/err    - per-thread held result
//                rsp_ack                       - thread consumed its result
//                ft_busy                       - inhibit new issue
//                acc_ip/acc_tid/acc_start      - issue to accelerator
//                acc_done/done_tid/action/match- result from accelerator
//                stray_done                    - result for a non-INFLIGHT slot
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_thread_scheduler
    import acc_thread_scheduler_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int TID_WIDTH   = c_TID_WIDTH_DEFAULT,
    parameter int NUM_ACTIONS = c_NUM_ACTIONS_DEFAULT,
    parameter int TIMEOUT     = 15
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_THREADS-1:0]             req_valid,
    input  logic [32*NUM_THREADS-1:0]          req_ip,
    output logic [NUM_THREADS-1:0]             req_ack,
    output logic [NUM_THREADS-1:0]             rsp_valid,
    output logic [NUM_ACTIONS*NUM_THREADS-1:0] rsp_action,
    output logic [NUM_THREADS-1:0]             rsp_match,
    output logic [NUM_THREADS-1:0]             rsp_err,
    input  logic [NUM_THREADS-1:0]             rsp_ack,
    input  logic                               ft_busy,
    output logic [31:0]                        acc_ip,
    output logic [TID_WIDTH-1:0]               acc_tid,
    output logic                               acc_start,
    input  logic                               acc_done,
    input  logic [TID_WIDTH-1:0]               acc_done_tid,
    input  logic [NUM_ACTIONS-1:0]             acc_action,
    input  logic                               acc_match,
    output logic                               stray_done
);

    localparam int                   c_TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0]   c_TMR_MAX  = c_TMR_W'(TIMEOUT);
    localparam logic [TID_WIDTH-1:0] c_LAST_IDX = TID_WIDTH'(NUM_THREADS - 1);

    logic [NUM_THREADS-1:0] w_pending;
    logic [NUM_THREADS-1:0] w_inflight;
    logic [NUM_THREADS-1:0] w_arb_req;
    logic [NUM_THREADS-1:0] w_grant;
    logic [TID_WIDTH-1:0]   w_grant_idx;
    logic                   w_grant_valid;
    logic [TID_WIDTH-1:0]   r_ptr;
    logic                   w_stray;
    logic [31:0]            w_ip_arr [NUM_THREADS];

    // ------------------------------------------------------------------
    // Issue arbitration: only PENDING slots compete, and nobody competes
    // while the flow table is being programmed.
    // ------------------------------------------------------------------
    assign w_arb_req = w_pending & {NUM_THREADS{~ft_busy}};

    rr_arbiter #(
        .NUM_THREADS (NUM_THREADS),
        .IDX_WIDTH   (TID_WIDTH)
    ) u_rr_arbiter (
        .i_req         (w_arb_req),
        .i_ptr         (r_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // A return is stray when its slot is not waiting for one (late return
    // after timeout, or a result outliving a reset).
    assign w_stray = acc_done && !w_inflight[acc_done_tid];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            acc_start  <= 1'b0;
            acc_tid    <= '0;
            acc_ip     <= '0;
            stray_done <= 1'b0;
        end else begin
            acc_start  <= w_grant_valid;
            stray_done <= w_stray;
            if (w_grant_valid) begin
                acc_tid <= w_grant_idx;
                acc_ip  <= w_ip_arr[w_grant_idx];
                r_ptr   <= (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-thread slot: state machine, timeout timer and result registers
    // ------------------------------------------------------------------
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_slot
        slot_state_e             r_state;
        slot_state_e             w_state_next;
        logic [31:0]             r_ip;
        logic [c_TMR_W-1:0]      r_timer;
        logic [NUM_ACTIONS-1:0]  r_action;
        logic                    r_match;
        logic                    r_err;
        logic                    r_req_ack;
        logic                    w_hit;
        logic                    w_capture;
        logic                    w_finish_ok;
        logic                    w_finish_to;
        logic                    w_release;

        assign w_hit = acc_done && (acc_done_tid == TID_WIDTH'(t));

        always_comb begin
            w_state_next = r_state;
            w_capture    = 1'b0;
            w_finish_ok  = 1'b0;
            w_finish_to  = 1'b0;
            w_release    = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid[t]) begin
                        w_state_next = ST_PENDING;
                        w_capture    = 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (w_grant[t]) begin
                        w_state_next = ST_INFLIGHT;
                    end
                end
                ST_INFLIGHT: begin
                    // A real result landing on the timeout edge takes priority
                    if (w_hit) begin
                        w_state_next = ST_DONE;
                        w_finish_ok  = 1'b1;
                    end else if (r_timer == c_TMR_MAX) begin
                        w_state_next = ST_DONE;
                        w_finish_to  = 1'b1;
                    end
                end
                ST_DONE: begin
                    // req_valid is not looked at here: a same-edge re-request
                    // is picked up from IDLE on the following edge.
                    if (rsp_ack[t]) begin
                        w_state_next = ST_IDLE;
                        w_release    = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state   <= ST_IDLE;
                r_ip      <= '0;
                r_timer   <= '0;
                r_action  <= '0;
                r_match   <= 1'b0;
                r_err     <= 1'b0;
                r_req_ack <= 1'b0;
            end else begin
                r_state   <= w_state_next;
                r_req_ack <= w_capture;
                if (w_capture) begin
                    r_ip <= req_ip[32*t +: 32];
                end
                if (w_grant[t]) begin
                    r_timer <= '0;
                end else if ((r_state == ST_INFLIGHT) && (r_timer != c_TMR_MAX)) begin
                    r_timer <= r_timer + 1'b1;
                end
                if (w_finish_ok) begin
                    r_action <= acc_action;
                    r_match  <= acc_match;
                    r_err    <= 1'b0;
                end else if (w_finish_to) begin
                    r_action <= '0;
                    r_match  <= 1'b0;
                    r_err    <= 1'b1;
                end else if (w_release) begin
                    r_action <= '0;
                    r_match  <= 1'b0;
                    r_err    <= 1'b0;
                end
            end
        end

        assign w_pending[t]                          = (r_state == ST_PENDING);
        assign w_inflight[t]                         = (r_state == ST_INFLIGHT);
        assign w_ip_arr[t]                           = r_ip;
        assign req_ack[t]                            = r_req_ack;
        assign rsp_valid[t]                          = (r_state == ST_DONE);
        assign rsp_action[NUM_ACTIONS*t +: NUM_ACTIONS] = r_action;
        assign rsp_match[t]                          = r_match;
        assign rsp_err[t]                            = r_err;
    end

endmodule : acc_thread_scheduler
`default_nettype wire
